// File: rtl/gpmc_pkg.sv
// gpmc_pkg: shared FSM encoding and data width for the GPMC capture front-end.
package gpmc_pkg;

    localparam int GPMC_DATA_W = 16;

    typedef enum logic [2:0] {
        STATE_IDLE      = 3'd0,
        STATE_ADDR      = 3'd1,
        STATE_WAIT_DIR  = 3'd2,
        STATE_WRITE     = 3'd3,
        STATE_READ_REQ  = 3'd4,
        STATE_READ_WAIT = 3'd5,
        STATE_READ_HOLD = 3'd6
    } state_e;

endpackage

// File: rtl/gpmc_sync.sv
// gpmc_sync: STAGES-deep synchronizer chain for W bits with a selectable reset level.
module gpmc_sync #(
    parameter int           STAGES  = 2,
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [STAGES-1:0][W-1:0] chain_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            chain_q <= {STAGES{RST_VAL}};
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/gpmc_bus_capture.sv
// gpmc_bus_capture: turns the asynchronous muxed GPMC bus into single-cycle
// register read/write requests in the CLK_100M domain and drives read data back.
module gpmc_bus_capture
    import gpmc_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 8
) (
    input  logic                   CLK_100M,
    input  logic                   RST_N,
    input  logic [GPMC_DATA_W-1:0] GPMC_AD_IN,
    output logic [GPMC_DATA_W-1:0] GPMC_AD_OUT,
    output logic                   GPMC_AD_OE,
    input  logic                   GPMC_ADVN,
    input  logic                   GPMC_CSN1,
    input  logic                   GPMC_WEIN,
    input  logic                   GPMC_OEN,
    output logic [ADDR_W-1:0]      ADDR,
    output logic [GPMC_DATA_W-1:0] WR_DATA,
    output logic                   WR_STB,
    output logic                   RD_STB,
    input  logic [GPMC_DATA_W-1:0] RD_DATA,
    output logic                   BUSY
);

    logic                   advn_s, csn_s, wein_s, oen_s;
    logic [GPMC_DATA_W-1:0] ad_s;

    gpmc_sync #(.STAGES(SYNC_STAGES), .W(1), .RST_VAL(1'b1)) u_sync_advn (
        .clk_i(CLK_100M), .rst_ni(RST_N), .d_i(GPMC_ADVN), .q_o(advn_s)
    );
    gpmc_sync #(.STAGES(SYNC_STAGES), .W(1), .RST_VAL(1'b1)) u_sync_csn (
        .clk_i(CLK_100M), .rst_ni(RST_N), .d_i(GPMC_CSN1), .q_o(csn_s)
    );
    gpmc_sync #(.STAGES(SYNC_STAGES), .W(1), .RST_VAL(1'b1)) u_sync_wein (
        .clk_i(CLK_100M), .rst_ni(RST_N), .d_i(GPMC_WEIN), .q_o(wein_s)
    );
    gpmc_sync #(.STAGES(SYNC_STAGES), .W(1), .RST_VAL(1'b1)) u_sync_oen (
        .clk_i(CLK_100M), .rst_ni(RST_N), .d_i(GPMC_OEN), .q_o(oen_s)
    );
    gpmc_sync #(.STAGES(SYNC_STAGES), .W(GPMC_DATA_W), .RST_VAL('0)) u_sync_ad (
        .clk_i(CLK_100M), .rst_ni(RST_N), .d_i(GPMC_AD_IN), .q_o(ad_s)
    );

    state_e                 state_q, state_d;
    logic                   advn_dly_q, wein_dly_q;
    logic [GPMC_DATA_W-1:0] ad_dly_q;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [GPMC_DATA_W-1:0] wr_data_q, wr_data_d, ad_out_q, ad_out_d;
    logic                   wr_stb_q, wr_stb_d, oe_q, oe_d;
    logic                   advn_rise, wein_rise, pad_safe;

    // ad_dly_q lines up with the last low sample of ADVN/WEIN when their rise is seen
    assign advn_rise = advn_s & ~advn_dly_q;
    assign wein_rise = wein_s & ~wein_dly_q;
    assign pad_safe  = advn_s & wein_s;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        wr_stb_d  = 1'b0;
        ad_out_d  = ad_out_q;
        oe_d      = 1'b0;
        if (state_q != STATE_IDLE && csn_s) begin
            state_d = STATE_IDLE;
        end else begin
            case (state_q)
                STATE_IDLE:      state_d = !advn_s ? STATE_ADDR : STATE_IDLE;
                STATE_ADDR: begin
                    if (advn_rise) begin
                        addr_d  = ad_dly_q[ADDR_W-1:0];
                        state_d = STATE_WAIT_DIR;
                    end
                end
                STATE_WAIT_DIR:  state_d = !wein_s ? STATE_WRITE :
                                           !oen_s  ? STATE_READ_REQ : STATE_WAIT_DIR;
                STATE_WRITE: begin
                    if (wein_rise) begin
                        wr_data_d = ad_dly_q;
                        wr_stb_d  = 1'b1;
                        state_d   = STATE_IDLE;
                    end
                end
                STATE_READ_REQ:  state_d = STATE_READ_WAIT;
                STATE_READ_WAIT: begin
                    ad_out_d = RD_DATA;
                    oe_d     = pad_safe;
                    state_d  = STATE_READ_HOLD;
                end
                STATE_READ_HOLD: begin
                    oe_d    = oe_q & pad_safe & ~oen_s;
                    state_d = oen_s ? STATE_IDLE : STATE_READ_HOLD;
                end
                default:         state_d = STATE_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK_100M or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= STATE_IDLE;
            advn_dly_q <= 1'b1;
            wein_dly_q <= 1'b1;
            ad_dly_q   <= '0;
            addr_q     <= '0;
            wr_data_q  <= '0;
            wr_stb_q   <= 1'b0;
            ad_out_q   <= '0;
            oe_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            advn_dly_q <= advn_s;
            wein_dly_q <= wein_s;
            ad_dly_q   <= ad_s;
            addr_q     <= addr_d;
            wr_data_q  <= wr_data_d;
            wr_stb_q   <= wr_stb_d;
            ad_out_q   <= ad_out_d;
            oe_q       <= oe_d;
        end
    end

    // gate with the synchronized controls so contention drops the driver without waiting an edge
    assign GPMC_AD_OE  = oe_q & pad_safe;
    assign GPMC_AD_OUT = ad_out_q;
    assign ADDR        = addr_q;
    assign WR_DATA     = wr_data_q;
    assign WR_STB      = wr_stb_q;
    assign RD_STB      = (state_q == STATE_READ_REQ);
    assign BUSY        = (state_q != STATE_IDLE);

endmodule

// File: tb/tb_gpmc_bus_capture.sv
// tb_gpmc_bus_capture: drives GPMC bus transactions and checks the resulting
// register requests and pad behaviour against a transaction-level model.
module tb_gpmc_bus_capture;

    localparam int SS = 2;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [15:0] ad_in = '0, ad_out, rd_data = '0, wr_data;
    logic        ad_oe, wr_stb, rd_stb, busy;
    logic        advn = 1'b1, csn = 1'b1, wein = 1'b1, oen = 1'b1;
    logic [7:0]  addr;

    int          n_pass = 0, n_total = 0;
    int          wr_cnt = 0, rd_cnt = 0, oe_cycles = 0;
    logic [7:0]  wr_addr_seen, rd_addr_seen;
    logic [15:0] wr_data_seen, last_wd;
    logic [15:0] regs [256];
    logic        rd_pend = 1'b0;
    logic [15:0] rd_val;

    always #5 clk = ~clk;

    gpmc_bus_capture #(.SYNC_STAGES(SS), .ADDR_W(8)) dut (
        .CLK_100M(clk), .RST_N(rst_n),
        .GPMC_AD_IN(ad_in), .GPMC_AD_OUT(ad_out), .GPMC_AD_OE(ad_oe),
        .GPMC_ADVN(advn), .GPMC_CSN1(csn), .GPMC_WEIN(wein), .GPMC_OEN(oen),
        .ADDR(addr), .WR_DATA(wr_data), .WR_STB(wr_stb), .RD_STB(rd_stb),
        .RD_DATA(rd_data), .BUSY(busy)
    );

    // bus monitor plus register-stage model: read data appears exactly one cycle after RD_STB
    always @(negedge clk) begin
        if (wr_stb === 1'b1) begin
            wr_cnt++;
            wr_addr_seen = addr;
            wr_data_seen = wr_data;
        end
        if (rd_stb === 1'b1) begin
            rd_cnt++;
            rd_addr_seen = addr;
        end
        if (ad_oe === 1'b1) oe_cycles++;
        rd_pend = (rd_stb === 1'b1);
        rd_val  = regs[addr];
    end

    always @(posedge clk) begin
        #1;
        rd_data = rd_pend ? rd_val : 16'($urandom);
    end

    task automatic tick(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic addr_phase(logic [7:0] a);
        csn   = 1'b0;
        advn  = 1'b0;
        ad_in = {8'($urandom), a};
        tick(SS + 2 + int'($urandom_range(0, 3)));
        advn  = 1'b1;
        ad_in = 16'($urandom);
        tick(SS + 2 + int'($urandom_range(0, 2)));
    endtask

    task automatic do_write(logic [7:0] a, logic [15:0] d, int wlen, bit with_oen, bit keep_cs);
        int w0, r0, o0;
        w0 = wr_cnt; r0 = rd_cnt; o0 = oe_cycles;
        addr_phase(a);
        wein  = 1'b0;
        ad_in = d;
        if (with_oen) oen = 1'b0;
        tick(wlen);
        wein  = 1'b1;
        ad_in = 16'($urandom);
        tick(SS + 2);
        oen = 1'b1;
        if (!keep_cs) csn = 1'b1;
        tick(SS + 2);
        regs[a] = d;
        last_wd = d;
        chk("wr_count", wr_cnt - w0, 1);
        chk("wr_addr", {24'd0, wr_addr_seen}, {24'd0, a});
        chk("wr_data", {16'd0, wr_data_seen}, {16'd0, d});
        chk("wr_no_rd", rd_cnt - r0, 0);
        chk("wr_no_oe", oe_cycles - o0, 0);
        if (!keep_cs) chk("wr_idle", {31'd0, busy}, 0);
    endtask

    task automatic do_read(logic [7:0] a, int olen, bit keep_cs);
        int w0, r0, n;
        logic [15:0] exp;
        w0 = wr_cnt; r0 = rd_cnt; exp = regs[a];
        addr_phase(a);
        oen   = 1'b0;
        ad_in = 16'($urandom);
        n = 0;
        while (ad_oe !== 1'b1 && n < 20) begin tick(); n++; end
        chk("rd_oe_latency", n, SS + 3);
        chk("rd_ad_out", {16'd0, ad_out}, {16'd0, exp});
        if (olen > n) tick(olen - n);
        chk("rd_oe_held", {31'd0, ad_oe}, 1);
        oen = 1'b1;
        n = 0;
        while (ad_oe !== 1'b0 && n < 20) begin tick(); n++; end
        chk("rd_oe_release", n, SS + 1);
        chk("rd_count", rd_cnt - r0, 1);
        chk("rd_addr", {24'd0, rd_addr_seen}, {24'd0, a});
        chk("rd_no_wr", wr_cnt - w0, 0);
        if (!keep_cs) csn = 1'b1;
        tick(SS + 2);
        chk("rd_out_hold", {16'd0, ad_out}, {16'd0, exp});
    endtask

    initial begin
        int w0, n;
        for (int i = 0; i < 256; i++) regs[i] = 16'($urandom);
        last_wd = '0;
        tick(3);
        chk("rst_oe", {31'd0, ad_oe}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_addr", {24'd0, addr}, 0);
        chk("rst_wr_data", {16'd0, wr_data}, 0);
        chk("rst_ad_out", {16'd0, ad_out}, 0);
        chk("rst_strobes", {30'd0, wr_stb, rd_stb}, 0);
        rst_n = 1'b1;
        tick(2);

        do_write(8'h12, 16'hBEEF, 10, 1'b0, 1'b0);
        regs[8'h34] = 16'hCAFE;
        do_read(8'h34, 12, 1'b0);

        // abort while waiting for direction, then a stray WEIN pulse with CSN high
        w0 = wr_cnt;
        addr_phase(8'h77);
        csn = 1'b1;
        tick(SS + 2);
        chk("abort_dir_idle", {31'd0, busy}, 0);
        wein = 1'b0; tick(6); wein = 1'b1; tick(SS + 2);
        chk("abort_dir_no_wr", wr_cnt - w0, 0);

        // abort mid-write: CSN rises before WEIN does
        w0 = wr_cnt;
        addr_phase(8'h78);
        wein = 1'b0; ad_in = 16'hDEAD;
        tick(6);
        csn = 1'b1;
        tick(SS + 2);
        chk("abort_wr_idle", {31'd0, busy}, 0);
        wein = 1'b1;
        tick(SS + 3);
        chk("abort_wr_no_wr", wr_cnt - w0, 0);
        chk("abort_wr_data", {16'd0, wr_data}, {16'd0, last_wd});

        // back-to-back with CSN held low throughout
        do_write(8'h01, 16'h1111, 8, 1'b0, 1'b1);
        do_read(8'h01, 12, 1'b0);

        // WEIN and OEN low together resolve as a write
        do_write(8'h55, 16'h5A5A, 10, 1'b1, 1'b0);

        // reset while the pad is driven
        addr_phase(8'h34);
        oen = 1'b0;
        n = 0;
        while (ad_oe !== 1'b1 && n < 20) begin tick(); n++; end
        chk("rst_rd_drive", {31'd0, ad_oe}, 1);
        tick(2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_oe", {31'd0, ad_oe}, 0);
        chk("arst_busy", {31'd0, busy}, 0);
        chk("arst_addr", {24'd0, addr}, 0);
        chk("arst_wr_data", {16'd0, wr_data}, 0);
        chk("arst_ad_out", {16'd0, ad_out}, 0);
        chk("arst_strobes", {30'd0, wr_stb, rd_stb}, 0);
        oen = 1'b1;
        csn = 1'b1;
        advn = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        do_write(8'h9C, 16'h0F0F, 6, 1'b0, 1'b0);
        do_read(8'h9C, 12, 1'b0);

        // randomized mix of reads and writes, sometimes back-to-back
        for (int k = 0; k < 20; k++) begin
            logic [7:0] a;
            bit         keep;
            a    = 8'($urandom);
            keep = (k != 19) && $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 1) == 1)
                do_write(a, 16'($urandom), int'($urandom_range(SS + 2, 10)), 1'b0, keep);
            else
                do_read(a, int'($urandom_range(10, 16)), keep);
        end
        csn = 1'b1;
        tick(4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
